// File: rtl/mrw_req_seq.sv
// mrw_req_seq: single-outstanding memory write/read request sequencer fed by a command FIFO.
// Optional watchdog on the wait states is built when MRW_REQ_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a buffered command; pops head when non-empty
// S_WR_REQ  | mw_en strobe with address/length/byte-enables
// S_WR_DATA | mw_data_en strobe with write data
// S_WR_WAIT | waiting for mw_op_over (or watchdog expiry)
// S_RD_REQ  | mr_en strobe with address/length/byte-enables
// S_RD_WAIT | capturing first read beat, waiting for mr_op_over (or watchdog)
// S_RSP     | response held on rsp_* until rsp_rdy
module mrw_req_seq #(
  parameter int DT_WD       = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             rc_core_clk,
  input  logic             rc_core_rstn,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_wr,
  input  logic [DT_WD-1:0] cmd_addr,
  input  logic [DT_WD-1:0] cmd_data,
  input  logic [7:0]       cmd_be,
  output logic             mw_en,
  output logic [DT_WD-1:0] mw_addr,
  output logic [11:0]      mw_len,
  output logic [DT_WD-1:0] mw_data,
  output logic [7:0]       mw_data_be,
  output logic             mw_data_en,
  input  logic             mw_op_over,
  output logic             mr_en,
  output logic [DT_WD-1:0] mr_addr,
  output logic [11:0]      mr_len,
  output logic [7:0]       mr_data_be,
  input  logic [DT_WD-1:0] mr_data,
  input  logic             mr_data_vld,
  input  logic             mr_op_over,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic             rsp_wr,
  output logic [DT_WD-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [11:0]   LEN_DW   = 12'(DT_WD / 32);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_DATA, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RSP
  } state_t;

  state_t state_q, state_d;

  logic             fifo_wr_q   [FIFO_DEPTH];
  logic [DT_WD-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DT_WD-1:0] fifo_data_q [FIFO_DEPTH];
  logic [7:0]       fifo_be_q   [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;

  logic             wr_q;
  logic [DT_WD-1:0] addr_q, data_q, cap_q, rsp_data_q;
  logic [7:0]       be_q;
  logic [11:0]      len_q;
  logic             cap_seen_q, rsp_wr_q;

  logic             push, pop, rsp_load, tmo, rd_done;
  logic [DT_WD-1:0] rd_val;

  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full rejects a push even if the head pops in the same cycle.
  assign cmd_rdy = rc_core_rstn && (cnt_q != FULL_CNT);
  assign push    = cmd_vld && cmd_rdy;

  always_ff @(posedge rc_core_clk) begin
    if (!rc_core_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= nxt_ptr(wptr_q);
      if (pop)  rptr_q <= nxt_ptr(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge rc_core_clk) begin
    if (push) begin
      fifo_wr_q[wptr_q]   <= cmd_wr;
      fifo_addr_q[wptr_q] <= cmd_addr;
      fifo_data_q[wptr_q] <= cmd_data;
      fifo_be_q[wptr_q]   <= cmd_be;
    end
  end

  always_ff @(posedge rc_core_clk) begin
    if (!rc_core_rstn) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rsp_load   = 1'b0;
    mw_en      = 1'b0;
    mw_data_en = 1'b0;
    mr_en      = 1'b0;
    rsp_vld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = fifo_wr_q[rptr_q] ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        mw_en   = 1'b1;
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        mw_data_en = 1'b1;
        state_d    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mw_op_over || tmo) begin
          rsp_load = 1'b1;
          state_d  = S_RSP;
        end
      end
      S_RD_REQ: begin
        mr_en   = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mr_op_over || tmo) begin
          rsp_load = 1'b1;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A beat arriving together with mr_op_over still counts as the first beat.
  assign rd_done = (state_q == S_RD_WAIT) && mr_op_over;
  assign rd_val  = cap_seen_q ? cap_q : (mr_data_vld ? mr_data : '0);

  always_ff @(posedge rc_core_clk) begin
    if (!rc_core_rstn) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      len_q      <= '0;
      cap_q      <= '0;
      cap_seen_q <= 1'b0;
      rsp_wr_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (pop) begin
        wr_q       <= fifo_wr_q[rptr_q];
        addr_q     <= fifo_addr_q[rptr_q];
        data_q     <= fifo_data_q[rptr_q];
        be_q       <= fifo_be_q[rptr_q];
        len_q      <= LEN_DW;
        cap_q      <= '0;
        cap_seen_q <= 1'b0;
      end else if ((state_q == S_RD_WAIT) && mr_data_vld && !cap_seen_q) begin
        cap_q      <= mr_data;
        cap_seen_q <= 1'b1;
      end
      if (rsp_load) begin
        rsp_wr_q   <= wr_q;
        rsp_data_q <= rd_done ? rd_val : '0;
      end
    end
  end

`ifdef MRW_REQ_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        rsp_err_q;
  logic        wr_done, in_wait;

  assign in_wait = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
  assign wr_done = (state_q == S_WR_WAIT) && mw_op_over;
  assign tmo     = in_wait && (wd_q == 16'd0);

  // Loaded in the cycle before each wait state so expiry lands TIMEOUT_CYC cycles after entry.
  always_ff @(posedge rc_core_clk) begin
    if (!rc_core_rstn) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if ((state_q == S_WR_DATA) || (state_q == S_RD_REQ)) wd_q <= 16'(TIMEOUT_CYC - 1);
      else if (in_wait && (wd_q != 16'd0))                 wd_q <= wd_q - 1'b1;
      if (rsp_load) rsp_err_q <= !(wr_done || rd_done);
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic [15:0] tmo_unused;
  assign tmo_unused = 16'(TIMEOUT_CYC);
  assign tmo        = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign mw_addr    = addr_q;
  assign mw_data    = data_q;
  assign mw_data_be = be_q;
  assign mw_len     = len_q;
  assign mr_addr    = addr_q;
  assign mr_data_be = be_q;
  assign mr_len     = len_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_mrw_req_seq.sv
// tb_mrw_req_seq: transaction-timeline model plus directed scenarios for mrw_req_seq.
// Define MRW_REQ_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC=16.
module tb_mrw_req_seq;

  localparam int DEPTH = 4;
`ifdef MRW_REQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rc_core_rstn;
  logic        cmd_vld, cmd_rdy, cmd_wr;
  logic [63:0] cmd_addr, cmd_data;
  logic [7:0]  cmd_be;
  logic        mw_en, mw_data_en, mw_op_over;
  logic [63:0] mw_addr, mw_data;
  logic [11:0] mw_len, mr_len;
  logic [7:0]  mw_data_be, mr_data_be;
  logic        mr_en, mr_data_vld, mr_op_over;
  logic [63:0] mr_addr, mr_data;
  logic        rsp_vld, rsp_rdy, rsp_wr, rsp_err;
  logic [63:0] rsp_data;

  always #5 clk = ~clk;

  mrw_req_seq #(.DT_WD(64), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .rc_core_clk(clk), .rc_core_rstn(rc_core_rstn),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_be(cmd_be),
    .mw_en(mw_en), .mw_addr(mw_addr), .mw_len(mw_len), .mw_data(mw_data),
    .mw_data_be(mw_data_be), .mw_data_en(mw_data_en), .mw_op_over(mw_op_over),
    .mr_en(mr_en), .mr_addr(mr_addr), .mr_len(mr_len), .mr_data_be(mr_data_be),
    .mr_data(mr_data), .mr_data_vld(mr_data_vld), .mr_op_over(mr_op_over),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s bound expired at %0t", nm, $time);
  endtask

  // ---------------- model: accepted-command queue and one transaction timeline
  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } cmd_t;

  cmd_t        exp_q[$];
  cmd_t        cur;
  bit          busy = 0, done = 0, beat_seen = 0, exp_err = 0;
  int          cyc = 0, t_issue = 0, wait_start = 0, t_rsp = 0, idle_from = 0, n_rsp = 0;
  logic [63:0] beat_val = '0, exp_data = '0;

  always @(posedge clk) begin : model
    int   c, occ;
    cmd_t nc;
    c   = cyc;
    occ = exp_q.size();
    if (!rc_core_rstn) begin
      exp_q.delete();
      busy      = 0;
      done      = 0;
      idle_from = c + 1;
    end else begin
      if (busy && !done && c >= wait_start) begin
        if (!cur.wr && mr_data_vld && !beat_seen) begin
          beat_seen = 1;
          beat_val  = mr_data;
        end
        if ((cur.wr && mw_op_over) || (!cur.wr && mr_op_over)) begin
          done     = 1;
          t_rsp    = c + 1;
          exp_err  = 0;
          exp_data = cur.wr ? 64'd0 : (beat_seen ? beat_val : 64'd0);
        end
`ifdef MRW_REQ_TIMEOUT_EN
        else if (c == wait_start + TMO - 1) begin
          done     = 1;
          t_rsp    = c + 1;
          exp_err  = 1;
          exp_data = 64'd0;
        end
`endif
      end else if (busy && done && c >= t_rsp && rsp_rdy) begin
        busy      = 0;
        n_rsp++;
        idle_from = c + 1;
      end
      if (!busy && c >= idle_from && occ > 0) begin
        cur        = exp_q.pop_front();
        busy       = 1;
        done       = 0;
        beat_seen  = 0;
        beat_val   = '0;
        t_issue    = c + 1;
        wait_start = cur.wr ? c + 3 : c + 2;
      end
      if (cmd_vld && occ < DEPTH) begin
        nc.wr = cmd_wr; nc.addr = cmd_addr; nc.data = cmd_data; nc.be = cmd_be;
        exp_q.push_back(nc);
      end
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin : compare
    logic e_mw, e_md, e_mr, e_rsp;
    if (cyc > 0) begin
      e_mw  = busy && cur.wr && (cyc == t_issue);
      e_md  = busy && cur.wr && (cyc == t_issue + 1);
      e_mr  = busy && !cur.wr && (cyc == t_issue);
      e_rsp = busy && done && (cyc >= t_rsp);
      chk("cmd_rdy", cmd_rdy, rc_core_rstn && (exp_q.size() < DEPTH));
      chk("mw_en", mw_en, e_mw);
      chk("mw_data_en", mw_data_en, e_md);
      chk("mr_en", mr_en, e_mr);
      chk("rsp_vld", rsp_vld, e_rsp);
      if (busy && cur.wr && cyc >= t_issue) begin
        chk("mw_addr", mw_addr, cur.addr);
        chk("mw_data", mw_data, cur.data);
        chk("mw_data_be", mw_data_be, cur.be);
        chk("mw_len", mw_len, 64'd2);
      end
      if (busy && !cur.wr && cyc >= t_issue) begin
        chk("mr_addr", mr_addr, cur.addr);
        chk("mr_data_be", mr_data_be, cur.be);
        chk("mr_len", mr_len, 64'd2);
      end
      if (e_rsp) begin
        chk("rsp_wr", rsp_wr, cur.wr);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
      end
    end
  end

  // ---------------- memory-side responder
  int          wr_delay = 5;
  int          rd_mode  = 0;
  logic [63:0] rd_val   = '0;

  initial begin
    mw_op_over = 0; mr_op_over = 0; mr_data_vld = 0; mr_data = '0;
    forever begin
      @(negedge clk);
      if (mw_data_en) begin
        repeat (wr_delay) @(posedge clk);
        #1 mw_op_over = 1;
        @(posedge clk);
        #1 mw_op_over = 0;
      end else if (mr_en) begin
        @(posedge clk);
        #1;
        case (rd_mode)
          0: begin
            mr_data_vld = 1; mr_data = rd_val;
            @(posedge clk); #1 mr_data = ~rd_val;
            @(posedge clk); #1 mr_data_vld = 0; mr_data = '0; mr_op_over = 1;
            @(posedge clk); #1 mr_op_over = 0;
          end
          1: begin
            mr_data_vld = 1; mr_data = rd_val; mr_op_over = 1;
            @(posedge clk); #1 mr_data_vld = 0; mr_data = '0; mr_op_over = 0;
          end
          2: begin
            mr_op_over = 1;
            @(posedge clk); #1 mr_op_over = 0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
    int n = 0;
    cmd_vld = 1; cmd_wr = w; cmd_addr = a; cmd_data = d; cmd_be = b;
    while (!cmd_rdy && n < 200) begin tick(); n++; end
    if (!cmd_rdy) fail_now("push_accept");
    tick();
    cmd_vld = 0;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return mw_en;
      1:       return mw_data_en;
      2:       return mr_en;
      default: return rsp_vld;
    endcase
  endfunction

  task automatic wait_sig(input int s, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sig(s)) return;
    end
    fail_now(nm);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    fail_now("wait_idle");
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {mw_en, mw_data_en, mr_en, rsp_vld, rsp_wr, rsp_err, cmd_rdy}, 64'd0);
    chk({nm, "_dp"}, mw_addr | mw_data | mr_addr | rsp_data, 64'd0);
    chk({nm, "_len_be"}, {mw_len, mr_len, mw_data_be, mr_data_be}, 64'd0);
  endtask

  initial begin
    int t0, base;
    rc_core_rstn = 0; rsp_rdy = 1;
    cmd_vld = 0; cmd_wr = 0; cmd_addr = '0; cmd_data = '0; cmd_be = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rc_core_rstn = 1;
    #1 chk("rdy_after_reset", cmd_rdy, 1);

    // write: mw_en, mw_data_en next cycle, op_over 5 cycles after data
    wr_delay = 5;
    push(1, 64'h1000, 64'hA5A5_5A5A_1234_5678, 8'hFF);
    wait_sig(0, "wr_mw_en");
    t0 = cyc;
    chk("wr_len", mw_len, 64'd2);
    chk("wr_addr_lit", mw_addr, 64'h1000);
    @(negedge clk);
    chk("wr_data_en_lit", mw_data_en, 1);
    chk("wr_data_lit", mw_data, 64'hA5A5_5A5A_1234_5678);
    wait_sig(3, "wr_rsp");
    chk("wr_latency", cyc - t0, 64'd7);
    chk("wr_rsp_lit", {rsp_wr, rsp_err}, 64'b10);
    chk("wr_rsp_data_lit", rsp_data, 64'd0);
    wait_idle();

    // read, first beat of two captured
    rd_mode = 0; rd_val = 64'hDEAD_BEEF_0000_0001;
    push(0, 64'h2000, 64'h0, 8'h0F);
    wait_sig(3, "rd_rsp");
    chk("rd_rsp_data_lit", rsp_data, 64'hDEAD_BEEF_0000_0001);
    chk("rd_rsp_wr_lit", rsp_wr, 0);
    wait_idle();

    // beat and op_over together
    rd_mode = 1; rd_val = 64'h0123_4567_89AB_CDEF;
    push(0, 64'h2008, 64'h0, 8'hF0);
    wait_sig(3, "rd_same_rsp");
    chk("rd_same_lit", rsp_data, 64'h0123_4567_89AB_CDEF);
    wait_idle();

    // op_over with no beat
    rd_mode = 2;
    push(0, 64'h2010, 64'h0, 8'h3C);
    wait_sig(3, "rd_nobeat_rsp");
    chk("rd_nobeat_lit", rsp_data, 64'd0);
    wait_idle();

    // FIFO fill behind a held response, then drain in order
    base = n_rsp; rsp_rdy = 0; rd_mode = 0; rd_val = 64'h1111_2222_3333_4444;
    push(1, 64'h3000, 64'hCAFE_0000_0000_0000, 8'h81);
    wait_sig(3, "hold_rsp");
    push(0, 64'h4000, 64'h0, 8'h01);
    push(1, 64'h4008, 64'h0000_0000_0000_0B0B, 8'h02);
    push(0, 64'h4010, 64'h0, 8'h04);
    push(1, 64'h4018, 64'h0000_0000_0000_0D0D, 8'h08);
    chk("full_rdy_lit", cmd_rdy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_vld_lit", {rsp_vld, rsp_wr, mw_en, mr_en}, 64'b1100);
    end
    fork
      push(1, 64'h4020, 64'h0000_0000_0000_0E0E, 8'h10);
      begin repeat (3) tick(); rsp_rdy = 1; end
    join
    wait_idle();
    chk("drain_count_lit", n_rsp - base, 64'd6);

    // reset during write wait; late op_over must be ignored
    base = n_rsp; wr_delay = 8;
    push(1, 64'h5000, 64'h5555, 8'hFF);
    wait_sig(1, "rst_data_en");
    repeat (3) tick();
    rc_core_rstn = 0;
    tick();
    chk_all_zero("mid_reset");
    rc_core_rstn = 1;
    repeat (12) tick();
    chk("no_rsp_after_reset", n_rsp - base, 64'd0);
    chk("idle_after_reset_lit", {rsp_vld, mw_en, mr_en}, 64'd0);
    wr_delay = 2;
    push(1, 64'h5008, 64'h6666, 8'h0F);
    wait_idle();
    chk("post_reset_cmd", n_rsp - base, 64'd1);

`ifdef MRW_REQ_TIMEOUT_EN
    // read never answered: watchdog response 16 cycles after wait entry
    rd_mode = 3;
    push(0, 64'h6000, 64'h0, 8'hFF);
    wait_sig(2, "tmo_mr_en");
    t0 = cyc;
    wait_sig(3, "tmo_rsp");
    chk("tmo_latency", cyc - t0, 64'd17);
    chk("tmo_rsp_lit", {rsp_err, rsp_wr}, 64'b10);
    chk("tmo_data_lit", rsp_data, 64'd0);
    wait_idle();
    wr_delay = 3;
    push(1, 64'h6008, 64'h7777, 8'hFF);
    wait_idle();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrw_req_seq.md
MRW_REQ_SEQ -- requirements
Module: mrw_req_seq

Interface
REQ-001 SHALL have parameter DT_WD, default 64, data path width in bits (32 or 64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in rc_core_clk cycles (16-bit).
REQ-004 SHALL have ports: rc_core_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: rc_core_rstn  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: cmd_vld in 1, cmd_rdy out 1, cmd_wr in 1 (1=write, 0=read), cmd_addr in DT_WD, cmd_data in DT_WD, cmd_be in 8.
REQ-007 SHALL have ports: mw_en out 1, mw_addr out DT_WD, mw_len out 12, mw_data out DT_WD, mw_data_be out 8, mw_data_en out 1, mw_op_over in 1.
REQ-008 SHALL have ports: mr_en out 1, mr_addr out DT_WD, mr_len out 12, mr_data_be out 8, mr_data in DT_WD, mr_data_vld in 1, mr_op_over in 1.
REQ-009 SHALL have ports: rsp_vld out 1, rsp_rdy in 1, rsp_wr out 1, rsp_data out DT_WD, rsp_err out 1.

Function
REQ-010 SHALL buffer commands in FIFO_DEPTH-entry FIFO; push on cmd_vld&&cmd_rdy; cmd_rdy = !full (combinational from count only).
REQ-011 SHALL implement states IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_WAIT, RSP.
REQ-012 IDLE: FIFO non-empty -> pop head same cycle, go WR_REQ if cmd_wr else RD_REQ; empty -> stay.
REQ-013 WR_REQ: mw_en=1 exactly one cycle with mw_addr, mw_len, mw_data_be valid; -> WR_DATA.
REQ-014 WR_DATA: mw_data_en=1 exactly one cycle with mw_data; -> WR_WAIT.
REQ-015 WR_WAIT: on mw_op_over -> RSP with rsp_wr=1, rsp_data=0, rsp_err=0.
REQ-016 RD_REQ: mr_en=1 exactly one cycle with mr_addr, mr_len, mr_data_be; -> RD_WAIT.
REQ-017 RD_WAIT: capture mr_data on first mr_data_vld only; later beats ignored; on mr_op_over -> RSP with captured data (0 if no beat seen), rsp_wr=0.
REQ-018 mr_data_vld and mr_op_over in same cycle: that beat captured and returned.
REQ-019 RSP: rsp_vld=1, rsp_* stable until rsp_rdy; on rsp_vld&&rsp_rdy -> IDLE; at most one outstanding transaction.
REQ-020 mw_len = mr_len = DT_WD/32 (DW count); every command single-beat.
REQ-021 mw_addr/mw_data/mw_data_be/mr_addr/mr_data_be SHALL hold the popped command from WR_REQ/RD_REQ until next pop.
REQ-022 mw_op_over/mr_op_over/mr_data_vld outside matching wait state SHALL be ignored.
REQ-023 Pop and push in same cycle SHALL both succeed when FIFO not full; full FIFO rejects push (cmd_rdy=0) even if pop occurs that cycle.

Reset
REQ-024 rc_core_rstn=0 at a rising edge SHALL force IDLE, empty FIFO, clear captured data and watchdog.
REQ-025 All outputs SHALL be 0 in reset except cmd_rdy=0 during reset and 1 the first cycle after.
REQ-026 Reset mid-transaction SHALL abandon it without emitting rsp_vld; late op_over after reset ignored per REQ-022.

Configuration
REQ-027 Macro MRW_REQ_TIMEOUT_EN defined: 16-bit counter runs in WR_WAIT/RD_WAIT, cleared on entry; reaching TIMEOUT_CYC -> RSP with rsp_err=1, rsp_data=0, rsp_wr per command.
REQ-028 Macro undefined: no counter; wait states persist until op_over; rsp_err tied 0.

Verification
REQ-029 Write cmd addr=0x1000, data=0xA5A5_5A5A_1234_5678, be=0xFF -> mw_en 1 cycle, mw_data_en next cycle, mw_len=2; op_over 5 cycles later -> rsp_vld, rsp_wr=1, rsp_err=0.
REQ-030 Read addr=0x2000; return mr_data_vld with 0xDEAD_BEEF_0000_0001 then op_over -> rsp_data=0xDEAD_BEEF_0000_0001, rsp_wr=0.
REQ-031 Push 5 commands back-to-back with DUT stalled -> cmd_rdy falls after 4th; 5th accepted after first pop; all 5 complete in order.
REQ-032 Hold rsp_rdy=0 for 10 cycles -> rsp_* stable, no new mw_en/mr_en issued.
REQ-033 MRW_REQ_TIMEOUT_EN, TIMEOUT_CYC=16, read never answered -> rsp_err=1, rsp_data=0 16 cycles after RD_WAIT entry; next command then proceeds.
REQ-034 Assert rc_core_rstn=0 during WR_WAIT -> next cycle all outputs 0, no rsp_vld; subsequent stray mw_op_over ignored.
